uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_if.sv | 18 +
 rtl/uart_tx_frame.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
//   AXI-Stream style character handshake between a producer and uart_tx_frame.
//   Parameter DATA_BITS sets the character width.
//   Signals:
//     axis_tdata  - character to send (producer -> transmitter)
//     axis_tvalid - producer has a character (producer -> transmitter)
//     axis_tready - transmitter can accept a character (transmitter -> producer)
//   Modports: master = producer side, slave = transmitter side.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] axis_tdata;
  logic                 axis_tvalid;
  logic                 axis_tready;

  modport master (output axis_tdata, output axis_tvalid, input axis_tready);
  modport slave  (input axis_tdata, input axis_tvalid, output axis_tready);
endinterface

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Parametrised UART transmitter. Takes one character per stream beat and
//   serialises it LSB first: start bit, DATA_BITS data bits, optional parity
//   bit, STOP_BITS stop bits. Every bit lasts exactly CLKS_PER_BIT cycles.
//   Ports:
//     clk     - clock
//     rst     - asynchronous active-high reset
//     axis    - character handshake (slave modport: axis_tdata/axis_tvalid in,
//               axis_tready out)
//     tx_data - serial line, idle high (registered)
//     busy    - a frame is in progress (registered)
//   Build option: define UART_TX_PARITY_EN to compile in the parity state;
//   PARITY then selects 0 = none, 1 = odd, 2 = even. Without the macro the
//   PARITY parameter is ignored and frames carry no parity bit.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line high, ready for a character
//   S_START | driving the start bit (low)
//   S_DATA  | driving data bits, LSB first
//   S_PAR   | driving the parity bit (parity build only)
//   S_STOP  | driving STOP_BITS stop bits (high)
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_frame_if.slave    axis,
  output logic              tx_data,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t               state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 tx_q, tx_n;
  logic                 ready_q, ready_n;
  logic                 busy_q, busy_n;
  logic                 tc;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign tc = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    shift_n = shift_q;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    // Bit timer free-runs 0..CLKS_PER_BIT-1 while a frame is active.
    if (state_q != S_IDLE) begin
      cnt_n = tc ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (axis.axis_tvalid && ready_q) begin
          state_n = S_START;
          shift_n = axis.axis_tdata;
          cnt_n   = '0;
          idx_n   = '0;
`ifdef UART_TX_PARITY_EN
          // Parity is fixed at capture so later input changes cannot leak in.
          par_n   = (PARITY == 1) ? ~^axis.axis_tdata : ^axis.axis_tdata;
`endif
        end
      end
      S_START: begin
        if (tc) state_n = S_DATA;
      end
      S_DATA: begin
        if (tc) begin
          shift_n = shift_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = (PARITY != 0) ? S_PAR : S_STOP;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (tc) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        if (tc) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_n   = '0;
            state_n = S_IDLE;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    ready_n = (state_n == S_IDLE);
    busy_n  = (state_n != S_IDLE);
  end

  assign axis.axis_tready = ready_q;
  assign tx_data          = tx_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
//   Runs several transmitter configurations side by side (8N1, 7N2, 9N1, and
//   8E1/8O1 when UART_TX_PARITY_EN is defined) at CLKS_PER_BIT = 4.
//   Stimulus pushes each accepted character into a per-DUT queue; a monitor
//   pops on each detected start bit and checks the line cycle by cycle.
module tb_uart_tx_frame;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NDUT = 5;
`else
  localparam int NDUT = 3;
`endif
  localparam int CD [5] = '{8, 7, 9, 8, 8};
  localparam int CS [5] = '{1, 2, 1, 1, 1};
  localparam int CP [5] = '{0, 0, 0, 2, 1};

  logic clk = 1'b0;
  logic rst;
  logic [8:0]      tdata [NDUT];
  logic [NDUT-1:0] tvalid;
  logic [NDUT-1:0] rdy;
  logic [NDUT-1:0] tx;
  logic [NDUT-1:0] busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [NDUT][$];
  logic [8:0] cur     [NDUT];
  int         cyc     [NDUT];
  bit         infr    [NDUT];
  bit         gap     [NDUT];
  bit         must_st [NDUT];
  int         frames  [NDUT];
  int         pushed  [NDUT];
  int         aborted [NDUT];

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(9)) if2 ();
  assign if0.axis_tdata  = tdata[0][7:0];
  assign if0.axis_tvalid = tvalid[0];
  assign rdy[0]          = if0.axis_tready;
  assign if1.axis_tdata  = tdata[1][6:0];
  assign if1.axis_tvalid = tvalid[1];
  assign rdy[1]          = if1.axis_tready;
  assign if2.axis_tdata  = tdata[2];
  assign if2.axis_tvalid = tvalid[2];
  assign rdy[2]          = if2.axis_tready;

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .axis(if0), .tx_data(tx[0]), .busy(busy[0]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .STOP_BITS(2), .PARITY(0)) dut1 (
    .clk(clk), .rst(rst), .axis(if1), .tx_data(tx[1]), .busy(busy[1]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(9), .STOP_BITS(1), .PARITY(0)) dut2 (
    .clk(clk), .rst(rst), .axis(if2), .tx_data(tx[2]), .busy(busy[2]));

`ifdef UART_TX_PARITY_EN
  uart_tx_frame_if #(.DATA_BITS(8)) if3 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if4 ();
  assign if3.axis_tdata  = tdata[3][7:0];
  assign if3.axis_tvalid = tvalid[3];
  assign rdy[3]          = if3.axis_tready;
  assign if4.axis_tdata  = tdata[4][7:0];
  assign if4.axis_tvalid = tvalid[4];
  assign rdy[4]          = if4.axis_tready;

  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY(2)) dut3 (
    .clk(clk), .rst(rst), .axis(if3), .tx_data(tx[3]), .busy(busy[3]));
  uart_tx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .STOP_BITS(1), .PARITY(1)) dut4 (
    .clk(clk), .rst(rst), .axis(if4), .tx_data(tx[4]), .busy(busy[4]));
`endif

  function automatic void chk(string name, int i, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, i, got, exp, $time);
    end
  endfunction

  function automatic int flen(int i);
    return (1 + CD[i] + ((CP[i] != 0) ? 1 : 0) + CS[i]) * C;
  endfunction

  // Expected line level k cycles into a frame carrying character ch.
  function automatic logic exp_bit(int k, logic [8:0] ch, int d, int p);
    int b;
    b = k / C;
    if (b == 0) return 1'b0;
    if (b <= d) return ch[b-1];
    if (p != 0 && b == d + 1) return (p == 2) ? ^ch : ~^ch;
    return 1'b1;
  endfunction

  // Monitor
  initial begin
    for (int i = 0; i < NDUT; i++) begin
      infr[i] = 0; gap[i] = 0; must_st[i] = 0; cyc[i] = 0; cur[i] = '0;
      frames[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (rst) begin
          infr[i] = 0; gap[i] = 0; must_st[i] = 0;
        end else begin
          if (gap[i]) begin
            chk("gap_tx", i, tx[i], 1);
            chk("gap_ready", i, rdy[i], 1);
            chk("gap_busy", i, busy[i], 0);
            gap[i] = 0;
            must_st[i] = tvalid[i];
          end else if (!infr[i]) begin
            if (must_st[i]) chk("b2b_start", i, tx[i], 0);
            must_st[i] = 0;
            if (tx[i] == 1'b0) begin
              if (exp_q[i].size() == 0) begin
                chk("unexpected_frame", i, 1, 0);
                cur[i] = '0;
              end else begin
                cur[i] = exp_q[i].pop_front();
              end
              infr[i] = 1; cyc[i] = 0;
            end
          end
          if (infr[i]) begin
            chk("tx_bit", i, tx[i], exp_bit(cyc[i], cur[i], CD[i], CP[i]));
            chk("busy_in_frame", i, busy[i], 1);
            chk("ready_in_frame", i, rdy[i], 0);
            cyc[i]++;
            if (cyc[i] == flen(i)) begin
              infr[i] = 0; gap[i] = 1; frames[i]++;
            end
          end
        end
      end
    end
  end

  task automatic send(int i, logic [8:0] ch, bit keep);
    int n;
    n = 0;
    @(posedge clk); #1;
    tdata[i]  = ch;
    tvalid[i] = 1'b1;
    @(negedge clk);
    while (!rdy[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", i, rdy[i], 1);
    if (!rdy[i]) begin
      tvalid[i] = 1'b0;
      return;
    end
    exp_q[i].push_back(ch & (9'h1FF >> (9 - CD[i])));
    pushed[i]++;
    @(posedge clk); #1;
    if (!keep) tvalid[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    @(negedge clk);
    while ((infr[i] || gap[i] || busy[i] || exp_q[i].size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", i, (n < 500), 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk("rst_tx", i, tx[i], 1);
      chk("rst_ready", i, rdy[i], 0);
      chk("rst_busy", i, busy[i], 0);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) chk("ready_before_edge", i, rdy[i], 0);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("ready_after_release", i, rdy[i], 1);
      chk("idle_tx", i, tx[i], 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tvalid = '0;
    for (int i = 0; i < NDUT; i++) begin
      tdata[i] = '0; pushed[i] = 0; aborted[i] = 0;
    end
    repeat (2) @(posedge clk);
    reset_pulse();

    // First character on every configuration, in parallel.
    fork
      send(0, 9'h0A5, 0);
      send(1, 9'h07F, 0);
      send(2, 9'h100, 0);
`ifdef UART_TX_PARITY_EN
      send(3, 9'h007, 0);
      send(4, 9'h007, 0);
`endif
    join
    for (int i = 0; i < NDUT; i++) wait_idle(i);

    fork
      send(0, 9'h0C3, 0);
      send(1, 9'h02A, 0);
      send(2, 9'h1A6, 0);
`ifdef UART_TX_PARITY_EN
      send(3, 9'h0B4, 0);
      send(4, 9'h0B4, 0);
`endif
    join
    for (int i = 0; i < NDUT; i++) wait_idle(i);

    // Back-to-back with tvalid held; tdata wiggles while not ready.
    send(0, 9'h055, 1);
    repeat (3) @(negedge clk);
    tdata[0] = 9'h033;
    repeat (5) @(negedge clk);
    tdata[0] = 9'h0F0;
    send(0, 9'h0AA, 0);
    wait_idle(0);

    send(1, 9'h055, 1);
    send(1, 9'h02A, 0);
    wait_idle(1);

    reset_pulse();

    // Abort during data bit 3, then a clean frame.
    send(0, 9'h0FF, 0);
    repeat (16) @(posedge clk);
    reset_pulse();
    aborted[0]++;
    send(0, 9'h001, 0);
    wait_idle(0);

    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk("frames_done", i, frames[i], pushed[i] - aborted[i]);
      chk("queue_empty", i, exp_q[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
